// File: rtl/pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central hazard unit for the 5-stage pipeline. It decides, every cycle, which
// pipeline registers hold or take a bubble, and it selects the forwarding path
// for both execute-stage ALU operands. A small FSM remembers an instruction
// fetch that a redirect has made stale, so the late-arriving word is dropped.
// Two saturating counters record stall and redirect activity.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   rs1_d, rs2_d                decode-stage source registers
//   rs1_e, rs2_e                execute-stage source registers
//   rd_e, rd_m, rd_w            destination registers in execute/memory/writeback
//   mem_read_e                  execute-stage instruction is a load
//   reg_write_m, reg_write_w    register-write enables in memory/writeback
//   pc_src_e                    taken branch/jump resolved in execute
//   imem_ready                  instruction fetch completes this cycle
//   dmem_req_m, dmem_ready      data access in memory stage / completes this cycle
//   stall_*                     hold the PC or the named pipeline register
//   flush_*                     load a bubble into the named pipeline register
//   forward_a_e, forward_b_e    00 regfile, 10 memory result, 01 writeback result
//   fsm_state                   00 RUN, 01 FWAIT, 10 FKILL
//   stall_cycles, redirect_count  saturating performance counters
// ----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             mem_read_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             pc_src_e,
    input  logic             imem_ready,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_execute,
    output logic             stall_memory,
    output logic             flush_decode,
    output logic             flush_execute,
    output logic             flush_writeback,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FWAIT = 2'b01,
        ST_FKILL = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] redirect_count_r;
    logic             dmem_wait_s;
    logic             load_use_s;
    logic             imem_wait_s;
    logic             redirect_s;

    // Operand source select; the memory stage holds the younger result, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] rdm,
        input logic [4:0] rdw,
        input logic       wm,
        input logic       ww
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wm && (rdm != 5'd0) && (rdm == src)) begin
            sel = 2'b10;
        end else if (ww && (rdw != 5'd0) && (rdw == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    assign dmem_wait_s = dmem_req_m & ~dmem_ready;
    assign load_use_s  = mem_read_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    // While a stale fetch is outstanding, whatever arrives must not enter decode.
    assign imem_wait_s = ~imem_ready | (state_r == ST_FKILL);
    assign redirect_s  = pc_src_e & ~dmem_wait_s;

    // Prioritised stall/flush selection plus forwarding; reset forces bubbles everywhere.
    always_comb begin
        stall_fetch     = 1'b0;
        stall_decode    = 1'b0;
        stall_execute   = 1'b0;
        stall_memory    = 1'b0;
        flush_decode    = 1'b0;
        flush_execute   = 1'b0;
        flush_writeback = 1'b0;
        forward_a_e     = 2'b00;
        forward_b_e     = 2'b00;
        if (!rst_n) begin
            flush_decode    = 1'b1;
            flush_execute   = 1'b1;
            flush_writeback = 1'b1;
        end else begin
            forward_a_e = fwd_sel(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w);
            forward_b_e = fwd_sel(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w);
            if (dmem_wait_s) begin
                // Execute is frozen, so a pending redirect or load-use simply persists.
                stall_fetch     = 1'b1;
                stall_decode    = 1'b1;
                stall_execute   = 1'b1;
                stall_memory    = 1'b1;
                flush_writeback = 1'b1;
            end else if (pc_src_e) begin
                // PC must load the target, so fetch is never stalled here.
                flush_decode  = 1'b1;
                flush_execute = 1'b1;
            end else if (load_use_s) begin
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                flush_execute = 1'b1;
            end else if (imem_wait_s) begin
                stall_fetch  = 1'b1;
                flush_decode = 1'b1;
            end else begin
                stall_fetch = 1'b0;
            end
        end
    end

    // Fetch-tracking next state; frozen while the data memory stalls the pipe.
    always_comb begin
        state_nxt_s = state_r;
        if (dmem_wait_s) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!imem_ready && pc_src_e) begin
                        state_nxt_s = ST_FKILL;
                    end else if (!imem_ready) begin
                        state_nxt_s = ST_FWAIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FWAIT: begin
                    if (!imem_ready && pc_src_e) begin
                        state_nxt_s = ST_FKILL;
                    end else if (imem_ready) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_FWAIT;
                    end
                end
                ST_FKILL: begin
                    if (imem_ready) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_FKILL;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r   <= {CNT_W{1'b0}};
            redirect_count_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_fetch) begin
                stall_cycles_r <= sat_inc(stall_cycles_r);
            end
            if (redirect_s) begin
                redirect_count_r <= sat_inc(redirect_count_r);
            end
        end
    end

    assign fsm_state      = state_r;
    assign stall_cycles   = stall_cycles_r;
    assign redirect_count = redirect_count_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// Directed testbench for pipeline_hazard_controller. A 32-bit-counter instance
// carries the main checks; a 4-bit-counter instance shares all inputs and is
// used for the counter-saturation check.
// Control outputs are compared as one vector:
//   {stall_fetch, stall_decode, stall_execute, stall_memory,
//    flush_decode, flush_execute, flush_writeback}
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        mem_read_e, reg_write_m, reg_write_w, pc_src_e;
    logic        imem_ready, dmem_req_m, dmem_ready;

    logic        stall_fetch, stall_decode, stall_execute, stall_memory;
    logic        flush_decode, flush_execute, flush_writeback;
    logic [1:0]  forward_a_e, forward_b_e, fsm_state;
    logic [31:0] stall_cycles, redirect_count;

    logic        n_sf, n_sd, n_se, n_sm, n_fd, n_fe, n_fw;
    logic [1:0]  n_fa, n_fb, n_st;
    logic [3:0]  n_stall_cycles, n_redirect_count;

    logic [6:0]  ctl;
    int          errors;
    int          checks;

    assign ctl = {stall_fetch, stall_decode, stall_execute, stall_memory,
                  flush_decode, flush_execute, flush_writeback};

    pipeline_hazard_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .mem_read_e(mem_read_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .imem_ready(imem_ready),
        .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .stall_execute(stall_execute), .stall_memory(stall_memory),
        .flush_decode(flush_decode), .flush_execute(flush_execute),
        .flush_writeback(flush_writeback),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .fsm_state(fsm_state),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    pipeline_hazard_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .mem_read_e(mem_read_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .imem_ready(imem_ready),
        .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_fetch(n_sf), .stall_decode(n_sd),
        .stall_execute(n_se), .stall_memory(n_sm),
        .flush_decode(n_fd), .flush_execute(n_fe),
        .flush_writeback(n_fw),
        .forward_a_e(n_fa), .forward_b_e(n_fb),
        .fsm_state(n_st),
        .stall_cycles(n_stall_cycles), .redirect_count(n_redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Benign input values: no hazards, both memories ready.
    task automatic idle();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        mem_read_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        pc_src_e = 1'b0; imem_ready = 1'b1; dmem_req_m = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        mem_read_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3; pc_src_e = 1'b1;
        reg_write_m = 1'b1; rd_m = 5'd4; rs1_e = 5'd4;
        rst_n = 1'b0;
        #2;
        checks++;
        if (ctl !== 7'b0000111) begin
            errors++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0000111);
        end
        checks++;
        if ({forward_a_e, forward_b_e, fsm_state} !== 6'b000000) begin
            errors++; $display("FAIL reset_fwd_state: got %b want 000000", {forward_a_e, forward_b_e, fsm_state});
        end
        checks++;
        if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, redirect_count);
        end
        step();
        idle();
        rst_n = 1'b1;
        #2;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL post_reset_idle: got %b want 0000000", ctl);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        mem_read_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
        #2;
        checks++;
        if (ctl !== 7'b1100010) begin
            errors++; $display("FAIL load_use_ctl: got %b want 1100010", ctl);
        end
        step();
        idle();
        reg_write_m = 1'b1; rd_m = 5'd5; rs2_e = 5'd5;
        #2;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL load_use_release: got %b want 0000000", ctl);
        end
        checks++;
        if (forward_b_e !== 2'b10 || forward_a_e !== 2'b00) begin
            errors++; $display("FAIL load_use_fwd: got a=%b b=%b want a=00 b=10", forward_a_e, forward_b_e);
        end
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cycles);
        end
        idle();
        mem_read_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
        #2;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL load_use_x0: got %b want 0000000", ctl);
        end
        step();
    endtask

    task automatic test_forward();
        idle();
        reg_write_m = 1'b1; reg_write_w = 1'b1; rd_m = 5'd7; rd_w = 5'd7; rs1_e = 5'd7;
        #2;
        checks++;
        if (forward_a_e !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_wins: got %b want 10", forward_a_e);
        end
        rd_m = 5'd0;
        #2;
        checks++;
        if (forward_a_e !== 2'b01) begin
            errors++; $display("FAIL fwd_wb: got %b want 01", forward_a_e);
        end
        rs1_e = 5'd0;
        #2;
        checks++;
        if (forward_a_e !== 2'b00) begin
            errors++; $display("FAIL fwd_x0: got %b want 00", forward_a_e);
        end
        rd_m = 5'd7; reg_write_m = 1'b0; rs2_e = 5'd7;
        #2;
        checks++;
        if (forward_b_e !== 2'b01) begin
            errors++; $display("FAIL fwd_b_mem_disabled: got %b want 01", forward_b_e);
        end
        reg_write_m = 1'b1; rd_m = 5'd9; rs1_e = 5'd9;
        #2;
        checks++;
        if (forward_a_e !== 2'b10 || forward_b_e !== 2'b01) begin
            errors++; $display("FAIL fwd_split: got a=%b b=%b want a=10 b=01", forward_a_e, forward_b_e);
        end
        step();
    endtask

    task automatic test_branch_over_load_use();
        apply_reset();
        mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; pc_src_e = 1'b1;
        #2;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++; $display("FAIL branch_ctl: got %b want 0000110", ctl);
        end
        step();
        checks++;
        if (redirect_count !== 32'd1 || stall_cycles !== 32'd0 || fsm_state !== 2'b00) begin
            errors++; $display("FAIL branch_cnt: got redir=%0d stall=%0d st=%b want 1 0 00",
                               redirect_count, stall_cycles, fsm_state);
        end
    endtask

    task automatic test_stale_fetch();
        apply_reset();
        imem_ready = 1'b0; pc_src_e = 1'b1;
        #2;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++; $display("FAIL stale_redirect_ctl: got %b want 0000110", ctl);
        end
        step();
        checks++;
        if (fsm_state !== 2'b10) begin
            errors++; $display("FAIL stale_enter_fkill: got %b want 10", fsm_state);
        end
        pc_src_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (ctl !== 7'b1000100 || fsm_state !== 2'b10) begin
                errors++; $display("FAIL stale_wait%0d: got ctl=%b st=%b want 1000100 10", i, ctl, fsm_state);
            end
            step();
        end
        imem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== 7'b1000100) begin
            errors++; $display("FAIL stale_drop_ctl: got %b want 1000100", ctl);
        end
        step();
        checks++;
        if (fsm_state !== 2'b00 || stall_cycles !== 32'd4 || redirect_count !== 32'd1) begin
            errors++; $display("FAIL stale_done: got st=%b stall=%0d redir=%0d want 00 4 1",
                               fsm_state, stall_cycles, redirect_count);
        end
        #2;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL stale_resume: got %b want 0000000", ctl);
        end
    endtask

    task automatic test_fetch_wait();
        apply_reset();
        imem_ready = 1'b0;
        #2;
        checks++;
        if (ctl !== 7'b1000100) begin
            errors++; $display("FAIL fwait_ctl: got %b want 1000100", ctl);
        end
        step();
        checks++;
        if (fsm_state !== 2'b01) begin
            errors++; $display("FAIL fwait_state: got %b want 01", fsm_state);
        end
        imem_ready = 1'b1; pc_src_e = 1'b1;
        step();
        checks++;
        if (fsm_state !== 2'b00) begin
            errors++; $display("FAIL fwait_to_run: got %b want 00", fsm_state);
        end
        imem_ready = 1'b0;
        step();
        step();
        checks++;
        if (fsm_state !== 2'b10 || ctl !== 7'b0000110) begin
            errors++; $display("FAIL fkill_redirect_hold: got st=%b ctl=%b want 10 0000110", fsm_state, ctl);
        end
        imem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++; $display("FAIL fkill_ready_redirect: got %b want 0000110", ctl);
        end
        step();
        checks++;
        if (fsm_state !== 2'b00 || redirect_count !== 32'd4) begin
            errors++; $display("FAIL fkill_exit: got st=%b redir=%0d want 00 4", fsm_state, redirect_count);
        end
    endtask

    task automatic test_dmem_freeze();
        apply_reset();
        dmem_req_m = 1'b1; dmem_ready = 1'b0; pc_src_e = 1'b1; imem_ready = 1'b0;
        mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (ctl !== 7'b1111001) begin
                errors++; $display("FAIL dmem_freeze%0d: got %b want 1111001", i, ctl);
            end
            step();
        end
        checks++;
        if (fsm_state !== 2'b00 || stall_cycles !== 32'd2 || redirect_count !== 32'd0) begin
            errors++; $display("FAIL dmem_hold: got st=%b stall=%0d redir=%0d want 00 2 0",
                               fsm_state, stall_cycles, redirect_count);
        end
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++; $display("FAIL dmem_release_ctl: got %b want 0000110", ctl);
        end
        step();
        checks++;
        if (fsm_state !== 2'b10 || redirect_count !== 32'd1) begin
            errors++; $display("FAIL dmem_release: got st=%b redir=%0d want 10 1", fsm_state, redirect_count);
        end
    endtask

    task automatic test_saturation_and_reset();
        apply_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        checks++;
        if (n_stall_cycles !== 4'd15 || stall_cycles !== 32'd20) begin
            errors++; $display("FAIL saturation: got narrow=%0d wide=%0d want 15 20", n_stall_cycles, stall_cycles);
        end
        pc_src_e = 1'b1;
        step();
        checks++;
        if (fsm_state !== 2'b10) begin
            errors++; $display("FAIL sat_fkill: got %b want 10", fsm_state);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (ctl !== 7'b0000111 || fsm_state !== 2'b00 || stall_cycles !== 32'd0 ||
            redirect_count !== 32'd0 || n_stall_cycles !== 4'd0) begin
            errors++; $display("FAIL mid_fkill_reset: got ctl=%b st=%b stall=%0d redir=%0d narrow=%0d want 0000111 00 0 0 0",
                               ctl, fsm_state, stall_cycles, redirect_count, n_stall_cycles);
        end
        step();
        idle();
        rst_n = 1'b1;
        step();
        checks++;
        if (fsm_state !== 2'b00 || ctl !== 7'b0000000) begin
            errors++; $display("FAIL post_release: got st=%b ctl=%b want 00 0000000", fsm_state, ctl);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        rst_n = 1'b0;
        step();
        test_reset();
        test_load_use();
        test_forward();
        test_branch_over_load_use();
        test_stale_fetch();
        test_fetch_wait();
        test_dmem_freeze();
        test_saturation_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
